piezo_alert_arb: RTL and testbench

//  Arbitrates the Segway audible alerts (too_fast, batt_low, en_steer) for the tune player feeding the piezo.

---
 rtl/piezo_alert_arb_if.sv | 24 ++
 rtl/piezo_alert_arb.sv | 155 +++++++++++++++
 tb/tb_piezo_alert_arb.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/piezo_alert_arb_if.sv
// Alert arbiter <-> tune player handshake bundle.
// master = arbiter side, slave = alert sources plus tune player side.
interface piezo_alert_arb_if;
  logic       too_fast;
  logic       batt_low;
  logic       en_steer;
  logic       tune_busy;
  logic       tune_done;
  logic       tune_start;
  logic [1:0] tune_sel;
  logic       tune_abort;
  logic       active;
  logic       err_ack_to;

  modport master (
    input  too_fast, batt_low, en_steer, tune_busy, tune_done,
    output tune_start, tune_sel, tune_abort, active, err_ack_to
  );

  modport slave (
    output too_fast, batt_low, en_steer, tune_busy, tune_done,
    input  tune_start, tune_sel, tune_abort, active, err_ack_to
  );
endinterface

// File: rtl/piezo_alert_arb.sv
// Piezo alert arbiter: FAST > BATT > STEER with preemption, repeat scheduling,
// silence gaps and a start/busy/done handshake toward the tune player.
module piezo_alert_arb #(
  parameter bit fast_sim = 1'b0,
  parameter int ACK_TO   = 16
) (
  input logic               clk,
  input logic               rst_n,
  piezo_alert_arb_if.master bus
);
  localparam int REPEAT_CYC = fast_sim ? 15_000 : 150_000_000;
  localparam int GAP_CYC    = fast_sim ? 250 : 2_500_000;
  localparam int BATT_QUAL  = fast_sim ? 500 : 5_000_000;
  localparam int ACK_W      = $clog2(ACK_TO + 1);

  localparam logic [27:0]      REP_MAX  = 28'(REPEAT_CYC);
  localparam logic [22:0]      QUAL_MAX = 23'(BATT_QUAL);
  localparam logic [21:0]      GAP_LAST = 22'(GAP_CYC - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TO - 1);

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_STEER = 2'b01;
  localparam logic [1:0] SEL_BATT  = 2'b10;
  localparam logic [1:0] SEL_FAST  = 2'b11;

  typedef enum logic [2:0] {IDLE, START, PLAY, ABORT, GAP} state_e;

  state_e           state_q;
  logic             tune_start_q, tune_abort_q, active_q, err_q;
  logic [1:0]       tune_sel_q, nxt_sel_q;
  logic [ACK_W-1:0] ack_cnt_q;
  logic [21:0]      gap_cnt_q;

  logic        en_steer_q, en_steer_d;
  logic [22:0] qual_cnt_q, qual_cnt_d;
  logic        batt_q, batt_d;
  logic        batt_hold_q, batt_hold_d;
  logic        steer_pend_q, steer_pend_d;
  logic        steer_hold_q, steer_hold_d;
  logic [27:0] rep_cnt_q, rep_cnt_d;

  logic       rep_hit, fast_req, batt_req, steer_req, start_now;
  logic [1:0] win, start_sel;

  // A source that already played waits for the repeat window before re-requesting.
  assign rep_hit   = (rep_cnt_q == REP_MAX);
  assign fast_req  = bus.too_fast;
  assign batt_req  = batt_q & (~batt_hold_q | rep_hit);
  assign steer_req = steer_pend_q | (steer_hold_q & bus.en_steer & rep_hit);
  assign win = fast_req ? SEL_FAST : batt_req ? SEL_BATT : steer_req ? SEL_STEER : SEL_NONE;

  always_comb begin
    start_now = 1'b0;
    start_sel = win;
    case (state_q)
      IDLE:  start_now = (win != SEL_NONE);
      ABORT: begin
        start_now = ~bus.tune_busy;
        start_sel = nxt_sel_q;
      end
      default: ;
    endcase
  end

  // rep_cnt loads 1 on the start edge so the hit lands one cycle before the
  // next start, making the start-to-start period exactly REPEAT_CYC.
  always_comb begin
    en_steer_d = bus.en_steer;
    qual_cnt_d = '0;
    if (bus.batt_low) qual_cnt_d = (qual_cnt_q == QUAL_MAX) ? qual_cnt_q : qual_cnt_q + 23'd1;
    batt_d       = bus.batt_low & (batt_q | (qual_cnt_d == QUAL_MAX));
    batt_hold_d  = batt_d & (batt_hold_q | (start_now & (start_sel == SEL_BATT)));
    steer_pend_d = bus.en_steer & (~en_steer_q |
                   (steer_pend_q & ~(start_now & (start_sel == SEL_STEER))));
    steer_hold_d = bus.en_steer & (steer_hold_q | (start_now & (start_sel == SEL_STEER)));
    rep_cnt_d    = start_now ? 28'd1 : (rep_hit ? rep_cnt_q : rep_cnt_q + 28'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_steer_q   <= 1'b0;
      qual_cnt_q   <= '0;
      batt_q       <= 1'b0;
      batt_hold_q  <= 1'b0;
      steer_pend_q <= 1'b0;
      steer_hold_q <= 1'b0;
      rep_cnt_q    <= '0;
    end else begin
      en_steer_q   <= en_steer_d;
      qual_cnt_q   <= qual_cnt_d;
      batt_q       <= batt_d;
      batt_hold_q  <= batt_hold_d;
      steer_pend_q <= steer_pend_d;
      steer_hold_q <= steer_hold_d;
      rep_cnt_q    <= rep_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tune_start_q <= 1'b0;
      tune_abort_q <= 1'b0;
      tune_sel_q   <= SEL_NONE;
      nxt_sel_q    <= SEL_NONE;
      active_q     <= 1'b0;
      err_q        <= 1'b0;
      ack_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      tune_start_q <= start_now;
      tune_abort_q <= 1'b0;
      if (start_now) begin
        state_q    <= START;
        tune_sel_q <= start_sel;
        active_q   <= 1'b1;
        ack_cnt_q  <= '0;
      end else begin
        case (state_q)
          START:
            if (bus.tune_busy) state_q <= PLAY;
            else if (ack_cnt_q == ACK_LAST) begin
              err_q      <= 1'b1;
              tune_sel_q <= SEL_NONE;
              active_q   <= 1'b0;
              state_q    <= IDLE;
            end else ack_cnt_q <= ack_cnt_q + 1'b1;
          // A natural finish wins over a same-cycle preempt.
          PLAY:
            if (bus.tune_done) begin
              gap_cnt_q <= 22'd1;
              state_q   <= GAP;
            end else if (win > tune_sel_q) begin
              tune_abort_q <= 1'b1;
              nxt_sel_q    <= win;
              state_q      <= ABORT;
            end
          GAP:
            if (gap_cnt_q >= GAP_LAST) begin
              tune_sel_q <= SEL_NONE;
              active_q   <= 1'b0;
              state_q    <= IDLE;
            end else gap_cnt_q <= gap_cnt_q + 22'd1;
          default: ;
        endcase
      end
    end
  end

  assign bus.tune_start = tune_start_q;
  assign bus.tune_sel   = tune_sel_q;
  assign bus.tune_abort = tune_abort_q;
  assign bus.active     = active_q;
  assign bus.err_ack_to = err_q;
endmodule

// File: tb/tb_piezo_alert_arb.sv
// Bench for piezo_alert_arb (fast_sim=1): scenario timing derived from the
// arbitration rules, randomized player latencies and a randomized FAST/STEER loop.
module tb_piezo_alert_arb;
  localparam int REP = 15000;
  localparam int GAP = 250;

  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0, n_err = 0, cyc = 0, n_start = 0, n_abort = 0, n_viol = 0;

  piezo_alert_arb_if bus();
  piezo_alert_arb #(.fast_sim(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  always #5 clk = ~clk;

  // Global properties: start/abort exclusive, no selection while inactive.
  always @(negedge clk) if (rst_n) begin
    if (bus.tune_start) n_start++;
    if (bus.tune_abort) n_abort++;
    if (bus.tune_start && bus.tune_abort) n_viol++;
    if (!bus.active && bus.tune_sel != 2'b00) n_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_start(input string tag, input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (!bus.tune_start && n < budget);
    chk({tag, "_seen"}, 32'(bus.tune_start), 1);
  endtask

  // Player: raise busy lat cycles after start, keep playing len cycles.
  task automatic serve(input int lat, input int len);
    idle(lat); bus.tune_busy = 1'b1; idle(len);
  endtask

  task automatic pulse_done();
    bus.tune_done = 1'b1; bus.tune_busy = 1'b0; tick(); bus.tune_done = 1'b0;
  endtask

  initial begin
    int n, s1, k, sd, ad;
    bit coin;
    rst_n = 1'b0;
    bus.too_fast = 1'b0; bus.batt_low = 1'b0; bus.en_steer = 1'b0;
    bus.tune_busy = 1'b0; bus.tune_done = 1'b0;
    #12;
    chk("rst_start", 32'(bus.tune_start), 0);
    chk("rst_abort", 32'(bus.tune_abort), 0);
    chk("rst_sel", 32'(bus.tune_sel), 0);
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_err", 32'(bus.err_ack_to), 0);
    #10 rst_n = 1'b1;
    tick();

    // STEER on rising edge, repeat exactly REP cycles start-to-start
    bus.en_steer = 1'b1;
    wait_start("t1a", 5, n);
    chk("t1a_sel", 32'(bus.tune_sel), 1);
    s1 = cyc;
    serve($urandom_range(0, 5), $urandom_range(60, 140));
    chk("t1_active", 32'(bus.active), 1);
    pulse_done();
    wait_start("t1b", REP + 1000, n);
    chk("t1b_sel", 32'(bus.tune_sel), 1);
    chk("t1b_period", cyc - s1, REP);
    serve(2, 50); bus.en_steer = 1'b0; pulse_done(); idle(GAP + 50);

    // batt_low qualification, then FAST arriving with BATT's done
    sd = n_start;
    bus.batt_low = 1'b1; idle(499); bus.batt_low = 1'b0; idle(20);
    chk("t2_short_batt", n_start - sd, 0);
    bus.batt_low = 1'b1;
    wait_start("t2", 600, n);
    chk("t2_lat", n, 501);
    chk("t2_sel", 32'(bus.tune_sel), 2);
    serve($urandom_range(0, 5), $urandom_range(20, 80));
    ad = n_abort;
    bus.too_fast = 1'b1; pulse_done();
    wait_start("t5", 400, n);
    chk("t5_gap", n + 1, GAP + 1);
    chk("t5_sel", 32'(bus.tune_sel), 3);
    chk("t5_no_abort", n_abort - ad, 0);
    serve(1, 30); bus.too_fast = 1'b0; bus.batt_low = 1'b0; pulse_done(); idle(GAP + 50);

    // FAST preempts STEER; restart right after busy drops
    bus.en_steer = 1'b1;
    wait_start("t3a", 5, n);
    chk("t3a_sel", 32'(bus.tune_sel), 1);
    serve($urandom_range(0, 5), $urandom_range(5, 40));
    bus.too_fast = 1'b1; tick();
    chk("t3_abort", 32'(bus.tune_abort), 1);
    chk("t3_abort_nostart", 32'(bus.tune_start), 0);
    k = $urandom_range(1, 6);
    sd = n_start;
    tick();
    chk("t3_abort_1cyc", 32'(bus.tune_abort), 0);
    idle(k - 1); bus.tune_busy = 1'b0;
    chk("t3_wait_busy", n_start - sd, 0);
    wait_start("t3b", 5, n);
    chk("t3b_lat", n, 1);
    chk("t3b_sel", 32'(bus.tune_sel), 3);
    serve(2, 20); bus.too_fast = 1'b0; bus.en_steer = 1'b0; pulse_done(); idle(GAP + 50);

    // ACK timeout, then service continues with the error held
    bus.en_steer = 1'b1;
    wait_start("t4", 5, n);
    idle(15);
    chk("t4_err_pre", 32'(bus.err_ack_to), 0);
    chk("t4_active_pre", 32'(bus.active), 1);
    tick();
    chk("t4_err", 32'(bus.err_ack_to), 1);
    chk("t4_sel", 32'(bus.tune_sel), 0);
    chk("t4_active", 32'(bus.active), 0);
    bus.too_fast = 1'b1;
    wait_start("t4b", 5, n);
    chk("t4b_lat", n, 1);
    chk("t4b_sel", 32'(bus.tune_sel), 3);
    chk("t4b_err", 32'(bus.err_ack_to), 1);
    serve(3, 20); bus.too_fast = 1'b0; bus.en_steer = 1'b0; pulse_done(); idle(GAP + 50);

    // Randomized FAST episodes, optionally with STEER pending underneath
    for (int it = 0; it < 4; it++) begin
      coin = 1'($urandom_range(0, 1));
      idle($urandom_range(1, 20));
      bus.too_fast = 1'b1; bus.en_steer = coin;
      wait_start("rf_a", 5, n);
      chk("rf_a_lat", n, 1);
      chk("rf_a_sel", 32'(bus.tune_sel), 3);
      serve($urandom_range(0, 8), $urandom_range(5, 60));
      pulse_done();
      wait_start("rf_b", 400, n);
      chk("rf_b_gap", n + 1, GAP + 1);
      chk("rf_b_sel", 32'(bus.tune_sel), 3);
      serve($urandom_range(0, 8), $urandom_range(5, 60));
      bus.too_fast = 1'b0; pulse_done();
      if (coin) begin
        wait_start("rf_c", 400, n);
        chk("rf_c_gap", n + 1, GAP + 1);
        chk("rf_c_sel", 32'(bus.tune_sel), 1);
        serve($urandom_range(0, 8), $urandom_range(5, 60));
        bus.en_steer = 1'b0; pulse_done(); idle(GAP + 10);
      end else begin
        sd = n_start; idle(GAP + 10);
        chk("rf_quiet", n_start - sd, 0);
      end
    end

    // Asynchronous reset mid-tune
    bus.en_steer = 1'b1;
    wait_start("t6", 5, n);
    serve(1, 10);
    chk("t6_active", 32'(bus.active), 1);
    bus.en_steer = 1'b0; tick();
    #3 rst_n = 1'b0; #1;
    chk("t6_active_rst", 32'(bus.active), 0);
    chk("t6_sel_rst", 32'(bus.tune_sel), 0);
    chk("t6_start_rst", 32'(bus.tune_start), 0);
    chk("t6_abort_rst", 32'(bus.tune_abort), 0);
    chk("t6_err_rst", 32'(bus.err_ack_to), 0);
    bus.tune_busy = 1'b0;
    #10 rst_n = 1'b1;
    sd = n_start;
    idle(40);
    chk("t6_quiet", n_start - sd, 0);

    chk("invariants", n_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
